reflet_timer_bank: RTL
======================

REFLET_TIMER_BANK -- requirements
Module: reflet_timer_bank

Interface
REQ-001 Parameter size, default 32: counter/limit width per channel.
REQ-002 Parameter channels, default 4: number of independent channels, 1..16.
REQ-003 Parameter prescale_size, default 8: prescaler width (used only under REFLET_TIMER_PRESCALER_EN).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  channels  per-channel count enable.
REQ-007 oneshot  input  channels  per-channel mode: 0 periodic, 1 one-shot.
REQ-008 restart  input  channels  per-channel synchronous clear pulse.
REQ-009 max  input  channels*size  per-channel limit, channel i at bits [i*size +: size].
REQ-010 prescale  input  prescale_size  tick divider value (present only under REFLET_TIMER_PRESCALER_EN).
REQ-011 out  output  channels  registered one-cycle pulse per wrap.
REQ-012 done  output  channels  one-shot completion flag.
REQ-013 count  output  channels*size  current counter value per channel, same packing as max.

Function
REQ-014 Shared tick: 1 every cycle without prescaler; channel i advances only on cycles with tick & enable[i] & !done[i].
REQ-015 Advance: counter >= max-1 -> counter wraps to 0 and out[i] is high in the following cycle for exactly one clk; otherwise counter+1.
REQ-016 Compare uses >=, so a max lowered below the current count wraps on the next advance, never runs to 2^size.
REQ-017 max==0: channel frozen, counter held, out[i]=0, done[i] unchanged.
REQ-018 max==1: every advance is a wrap; out[i] high every cycle following an advance (continuous 1 with enable held, tick every cycle).
REQ-019 Periodic with tick every cycle: out period exactly max cycles; first pulse max cycles after the first enabled cycle.
REQ-020 One-shot: the first wrap sets done[i] in the same cycle out[i] rises; channel then holds counter 0 and emits no further pulses until restart.
REQ-021 restart[i]: next cycle counter=0, done[i]=0, out[i]=0; takes priority over a same-cycle advance (that advance is discarded, no pulse).
REQ-022 Deasserting enable[i] holds counter; reassertion resumes from held value.
REQ-023 Changing oneshot[i] while done[i]=1 does not clear done; only restart or reset clears it.
REQ-024 Channels fully independent; simultaneous wraps on several channels each produce their own pulse.
REQ-025 count reflects registered counter (no combinational path from inputs).

Reset
REQ-026 reset low, asynchronously: all counters 0, out=0, done=0, prescaler counter 0.
REQ-027 Reset mid-count discards progress; after release the first advance yields count 1.

Configuration
REQ-028 Macro REFLET_TIMER_PRESCALER_EN defined: prescale port and shared divider present; tick high one cycle in every prescale+1 cycles (prescale=0 -> every cycle); divider free-runs independent of enables.
REQ-029 Macro absent: no prescale port, no divider logic, tick constant 1.
REQ-030 Changing prescale mid-run takes effect at the next divider wrap; divider compare also uses >=.

Structure
REQ-031 Package reflet_timer_pkg holds the mode constants (periodic=0, one-shot=1) and the max-channels constant (16).
REQ-032 Sub-module reflet_timer_channel implements one channel (counter, compare, pulse, done); top instantiates it channels times plus the shared divider.

Verification
REQ-033 Periodic: size=8, max=5, enable=1, no prescale -> out pulses at cycles 5,10,15 after enable; count cycles 1,2,3,4,0.
REQ-034 One-shot: max=3, oneshot=1 -> single pulse at cycle 3, done=1 thereafter, count stays 0 for 20 cycles; restart -> done=0, next pulse 3 cycles later.
REQ-035 Boundaries: max=0 -> out never high over 50 cycles; max=1 -> out high every cycle from cycle 1 to enable drop.
REQ-036 Restart collision: max=4, assert restart on the cycle count=3 -> no pulse, count=0 next cycle, next pulse 4 advances later.
REQ-037 Prescaler (macro on): prescale=2, max=3 -> pulse every 9 cycles; async reset asserted mid-period clears out, done, count immediately without a clock edge.
REQ-038 Shrink: count=7 with max=10, set max=4 -> wrap and pulse on the next advance; then period 4.

Source files
------------

// File: rtl/reflet_timer_pkg.sv
// Shared definitions for the reflet timer bank: channel modes and the channel ceiling.
// Optional prescaler is selected with the REFLET_TIMER_PRESCALER_EN macro in the top.
package reflet_timer_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/reflet_timer_channel.sv
// One timer channel: counter with >= limit compare, registered wrap pulse and one-shot done flag.
module reflet_timer_channel
  import reflet_timer_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_i,
  input  logic            enable_i,
  input  logic            oneshot_i,
  input  logic            restart_i,
  input  logic [size-1:0] max_i,
  output logic            out_o,
  output logic            done_o,
  output logic [size-1:0] count_o
);

  localparam logic [size-1:0] One = size'(1);

  logic [size-1:0] count_q, count_d;
  logic            out_q, out_d;
  logic            done_q, done_d;
  logic            advance;
  logic            atLimit;
  mode_e           mode;

  assign mode    = mode_e'(oneshot_i);
  // A zero limit freezes the channel; it also keeps max-1 from underflowing into the compare.
  assign advance = tick_i & enable_i & ~done_q & (max_i != '0);
  assign atLimit = count_q >= (max_i - One);

  always_comb begin
    count_d = count_q;
    out_d   = 1'b0;
    done_d  = done_q;
    if (restart_i) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (advance) begin
      if (atLimit) begin
        count_d = '0;
        out_d   = 1'b1;
        if (mode == MODE_ONESHOT) done_d = 1'b1;
      end else begin
        count_d = count_q + One;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out_o   = out_q;
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: rtl/reflet_timer_bank.sv
// Bank of independent timer channels sharing one tick.
// Define REFLET_TIMER_PRESCALER_EN to add the prescale port and shared tick divider.
module reflet_timer_bank
  import reflet_timer_pkg::*;
#(
  parameter int size          = 32,
  parameter int channels      = 4,
  parameter int prescale_size = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [channels-1:0]      enable,
  input  logic [channels-1:0]      oneshot,
  input  logic [channels-1:0]      restart,
  input  logic [channels*size-1:0] max,
`ifdef REFLET_TIMER_PRESCALER_EN
  input  logic [prescale_size-1:0] prescale,
`endif
  output logic [channels-1:0]      out,
  output logic [channels-1:0]      done,
  output logic [channels*size-1:0] count
);

  localparam int NumChannels = (channels < MAX_CHANNELS) ? channels : MAX_CHANNELS;

  logic tick;

`ifdef REFLET_TIMER_PRESCALER_EN
  logic [prescale_size-1:0] div_q, div_d;

  // Free-running divider; the >= compare lets a lowered prescale wrap promptly.
  assign tick  = div_q >= prescale;
  assign div_d = tick ? '0 : div_q + prescale_size'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NumChannels; i++) begin : g_channel
    reflet_timer_channel #(
      .size(size)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick),
      .enable_i (enable[i]),
      .oneshot_i(oneshot[i]),
      .restart_i(restart[i]),
      .max_i    (max[i*size +: size]),
      .out_o    (out[i]),
      .done_o   (done[i]),
      .count_o  (count[i*size +: size])
    );
  end

endmodule
